sio_lane_sequencer: RTL and testbench

//  Parametrised tristate lane sequencer for SPI-style SIO pads, 1/2/4-lane modes.

---
 rtl/sio_lane_sequencer_pkg.sv | 41 ++++
 rtl/sio_pad.sv | 17 +
 rtl/sio_lane_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sio_lane_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_lane_sequencer_pkg.sv
// Shared definitions for the SIO lane sequencer.
// Contents:
//   seq_state_t      FSM state encoding (IDLE / TURN / DUMMY / SHIFT)
//   MODE_X1/X2/X4    cmd_mode lane-mode codes (3 is treated as 4-lane)
//   DIR_WRITE/READ   cmd_dir codes
//   active_lanes()   lane count for a mode, clamped to the physical lane count
//   lane_mask()      one-hot-fill mask covering the active lanes
package sio_lane_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DUMMY = 2'd2,
        ST_SHIFT = 2'd3
    } seq_state_t;

    localparam logic [1:0] MODE_X1 = 2'd0;
    localparam logic [1:0] MODE_X2 = 2'd1;
    localparam logic [1:0] MODE_X4 = 2'd2;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    function automatic logic [2:0] active_lanes(input logic [1:0] mode, input int lanes);
        logic [2:0] k;
        case (mode)
            MODE_X1: k = 3'd1;
            MODE_X2: k = 3'd2;
            default: k = 3'd4;
        endcase
        if (int'(k) > lanes) begin
            k = 3'(lanes);
        end
        return k;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] k);
        return 4'((5'd1 << k) - 5'd1);
    endfunction

endpackage

// File: rtl/sio_pad.sv
// Single bidirectional SIO pad cell.
// Ports:
//   o    in    value driven onto the pad when oe is high
//   oe   in    output enable; pad floats (Z) when low
//   pad  inout the physical sio lane
//   i    out   pad value as seen on the wire (own drive or external)
module sio_pad (
    input  logic o,
    input  logic oe,
    inout  wire  pad,
    output logic i
);

    assign pad = oe ? o : 1'bz;
    assign i   = pad;

endmodule

// File: rtl/sio_lane_sequencer.sv
// Tristate lane sequencer for SPI-style SIO pads in 1/2/4-lane modes.
// Each accepted command runs one transaction: an optional one-cycle bus
// turnaround (when the direction flips), an optional run of dummy cycles,
// then an MSB-first word shift that either drives the lanes (write) or
// samples them (read). This block owns every pad output-enable.
// Ports:
//   sys_clk    in    clock, all logic on posedge
//   sys_rst_n  in    asynchronous active-low reset
//   sio        inout LANES pad lanes
//   cmd_valid  in    command offered
//   cmd_ready  out   command accepted on cmd_valid & cmd_ready (IDLE only)
//   cmd_dir    in    0 = write (drive), 1 = read (sample)
//   cmd_mode   in    0 = 1-lane, 1 = 2-lane, 2/3 = 4-lane (clamped to LANES)
//   cmd_dummy  in    dummy cycles ahead of the shift, 0 allowed
//   tx_data    in    write word, latched on accept
//   rx_data    out   read word, valid while rx_valid
//   rx_valid   out   one-cycle pulse on the first IDLE cycle after a read
//   busy       out   high whenever the FSM is not in IDLE
module sio_lane_sequencer
    import sio_lane_sequencer_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int WORD    = 8,
    parameter int DUMMY_W = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    inout  wire  [LANES-1:0]   sio,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [1:0]         cmd_mode,
    input  logic [DUMMY_W-1:0] cmd_dummy,
    input  logic [WORD-1:0]    tx_data,
    output logic [WORD-1:0]    rx_data,
    output logic               rx_valid,
    output logic               busy
);

    localparam int CNT_W = $clog2(WORD + 1);

    seq_state_t         state;
    seq_state_t         state_nx;

    logic               rst_done;
    logic               dir_q;
    logic               last_dir;
    logic [2:0]         lanes_q;
    logic [DUMMY_W-1:0] dummy_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WORD-1:0]    sreg;

    logic [LANES-1:0]   pad_o;
    logic [LANES-1:0]   pad_oe;
    logic [LANES-1:0]   pad_i;

    logic               accept;
    logic               last_beat;
    logic               eff_dir;
    logic [2:0]         eff_lanes;
    logic [LANES-1:0]   eff_mask;
    logic [WORD-1:0]    shifted;
    logic [WORD-1:0]    sample_ext;
    logic [WORD-1:0]    beat_src;
    logic [LANES-1:0]   pad_o_nx;
    logic [LANES-1:0]   pad_oe_nx;

    for (genvar g = 0; g < LANES; g++) begin : g_pad
        sio_pad u_pad (
            .o   (pad_o[g]),
            .oe  (pad_oe[g]),
            .pad (sio[g]),
            .i   (pad_i[g])
        );
    end

    assign accept    = cmd_valid & cmd_ready;
    // bit_cnt holds the bits still to move, so the final beat is the one
    // that consumes exactly the last k bits.
    assign last_beat = (bit_cnt == CNT_W'(lanes_q));

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_dir != last_dir) begin
                        state_nx = ST_TURN;
                    end else if (cmd_dummy != '0) begin
                        state_nx = ST_DUMMY;
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end
            end
            ST_TURN: begin
                state_nx = (dummy_cnt != '0) ? ST_DUMMY : ST_SHIFT;
            end
            ST_DUMMY: begin
                if (dummy_cnt == DUMMY_W'(1)) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_beat) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs; cmd_ready stays low until the first edge after reset release.
    always_comb begin
        cmd_ready = rst_done && (state == ST_IDLE);
        busy      = (state != ST_IDLE);
    end

    // Next pad drive. o/oe are registered, so the beat for the coming cycle is
    // computed here: on entry to SHIFT it is the top of the word (straight from
    // tx_data when entering from IDLE), inside SHIFT it is the top of the word
    // after this cycle's shift. oe follows the next state, which keeps every
    // lane floating in TURN, DUMMY and IDLE.
    always_comb begin
        eff_dir    = (state == ST_IDLE) ? cmd_dir : dir_q;
        eff_lanes  = (state == ST_IDLE) ? active_lanes(cmd_mode, LANES) : lanes_q;
        eff_mask   = LANES'(lane_mask(eff_lanes));
        shifted    = sreg << lanes_q;
        sample_ext = WORD'(pad_i & LANES'(lane_mask(lanes_q)));

        case (state)
            ST_IDLE:  beat_src = tx_data;
            ST_SHIFT: beat_src = shifted;
            default:  beat_src = sreg;
        endcase

        pad_oe_nx = '0;
        pad_o_nx  = '0;
        if (state_nx == ST_SHIFT && eff_dir == DIR_WRITE) begin
            pad_oe_nx = eff_mask;
            pad_o_nx  = LANES'(beat_src >> (WORD - int'(eff_lanes))) & eff_mask;
        end
    end

    // Transaction registers, counters and shift register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_done  <= 1'b0;
            dir_q     <= DIR_READ;
            last_dir  <= DIR_READ;
            lanes_q   <= 3'd1;
            dummy_cnt <= '0;
            bit_cnt   <= '0;
            sreg      <= '0;
            pad_o     <= '0;
            pad_oe    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            rx_valid <= 1'b0;
            pad_o    <= pad_o_nx;
            pad_oe   <= pad_oe_nx;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dir_q     <= cmd_dir;
                        lanes_q   <= eff_lanes;
                        dummy_cnt <= cmd_dummy;
                        bit_cnt   <= CNT_W'(WORD);
                        sreg      <= tx_data;
                    end
                end
                ST_DUMMY: begin
                    dummy_cnt <= dummy_cnt - DUMMY_W'(1);
                end
                ST_SHIFT: begin
                    // Read samples enter at the bottom so the first beat ends up
                    // in the most significant bits.
                    sreg    <= shifted | ((dir_q == DIR_READ) ? sample_ext : '0);
                    bit_cnt <= bit_cnt - CNT_W'(lanes_q);
                    if (last_beat) begin
                        last_dir <= dir_q;
                        if (dir_q == DIR_READ) begin
                            rx_data  <= shifted | sample_ext;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sio_lane_sequencer.sv
module tb_sio_lane_sequencer;

    localparam int WORD    = 8;
    localparam int DUMMY_W = 4;
    localparam int LANES_A = 4;
    localparam int LANES_B = 2;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic sys_rst_n;
    int   cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: 4 lanes ----------------
    wire  [LANES_A-1:0] sio_a;
    logic [LANES_A-1:0] drv_a, drv_oe_a;
    logic               cmd_valid_a, cmd_ready_a, cmd_dir_a;
    logic [1:0]         cmd_mode_a;
    logic [DUMMY_W-1:0] cmd_dummy_a;
    logic [WORD-1:0]    tx_data_a, rx_data_a;
    logic               rx_valid_a, busy_a;
    logic [LANES_A-1:0] oe_a;

    for (genvar g = 0; g < LANES_A; g++) begin : g_drv_a
        assign sio_a[g] = drv_oe_a[g] ? drv_a[g] : 1'bz;
    end

    sio_lane_sequencer #(.LANES(LANES_A), .WORD(WORD), .DUMMY_W(DUMMY_W)) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sio       (sio_a),
        .cmd_valid (cmd_valid_a),
        .cmd_ready (cmd_ready_a),
        .cmd_dir   (cmd_dir_a),
        .cmd_mode  (cmd_mode_a),
        .cmd_dummy (cmd_dummy_a),
        .tx_data   (tx_data_a),
        .rx_data   (rx_data_a),
        .rx_valid  (rx_valid_a),
        .busy      (busy_a)
    );
    assign oe_a = dut_a.pad_oe;

    // ---------------- DUT B: 2 lanes ----------------
    wire  [LANES_B-1:0] sio_b;
    logic               cmd_valid_b, cmd_ready_b, cmd_dir_b;
    logic [1:0]         cmd_mode_b;
    logic [DUMMY_W-1:0] cmd_dummy_b;
    logic [WORD-1:0]    tx_data_b, rx_data_b;
    logic               rx_valid_b, busy_b;
    logic [LANES_B-1:0] oe_b;

    sio_lane_sequencer #(.LANES(LANES_B), .WORD(WORD), .DUMMY_W(DUMMY_W)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sio       (sio_b),
        .cmd_valid (cmd_valid_b),
        .cmd_ready (cmd_ready_b),
        .cmd_dir   (cmd_dir_b),
        .cmd_mode  (cmd_mode_b),
        .cmd_dummy (cmd_dummy_b),
        .tx_data   (tx_data_b),
        .rx_data   (rx_data_b),
        .rx_valid  (rx_valid_b),
        .busy      (busy_b)
    );
    assign oe_b = dut_b.pad_oe;

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [3:0] val;
    } beat_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rx_t;

    beat_t wq_a[$];
    rx_t   rq_a[$];
    logic  last_dir_a = 1'b1;
    logic  last_dir_b = 1'b1;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lanes in use: 2^mode with modes 2 and 3 both meaning four, never more than the pads present.
    function automatic int model_lanes(input int mode, input int lanes);
        int w;
        w = (mode >= 2) ? 4 : (1 << mode);
        return (w < lanes) ? w : lanes;
    endfunction

    // Monitor: any cycle with a lane enabled must be an expected write beat;
    // any rx_valid must be an expected read completion.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (oe_a != '0) begin
                if (wq_a.size() == 0) begin
                    check("unexpected_drive", 32'(oe_a), 32'd0);
                end else begin
                    beat_t b;
                    b = wq_a.pop_front();
                    check("beat_cycle", cyc, b.cyc);
                    check("beat_oe", 32'(oe_a), 32'(b.mask));
                    check("beat_data", 32'(sio_a & b.mask), 32'(b.val));
                end
            end
            if (rx_valid_a) begin
                if (rq_a.size() == 0) begin
                    check("unexpected_rx_valid", 32'(rx_valid_a), 32'd0);
                end else begin
                    rx_t r;
                    r = rq_a.pop_front();
                    check("rx_cycle", cyc, r.cyc);
                    check("rx_data", 32'(rx_data_a), 32'(r.data));
                end
            end
        end
    end

    // One transaction on DUT A. Expectations are queued before the accept edge;
    // while the DUT is busy the command inputs carry random junk.
    task automatic txn_a(input logic dir, input logic [1:0] mode, input logic [3:0] dummy,
                         input logic [7:0] data, input bit fixed, input logic [31:0] pat);
        int         k, beats, t, dur, e, w;
        logic [3:0] mask;
        logic [3:0] lanev [8];
        logic [7:0] rx_exp;
        beat_t      b;
        rx_t        r;

        k     = model_lanes(int'(mode), LANES_A);
        beats = WORD / k;
        t     = (dir != last_dir_a) ? 1 : 0;
        dur   = t + int'(dummy) + beats;
        mask  = 4'((1 << k) - 1);

        w = 0;
        while (!cmd_ready_a && w < 40) begin
            @(posedge sys_clk); #1;
            w++;
        end
        if (!cmd_ready_a) begin
            check("ready_timeout", 32'(cmd_ready_a), 32'd1);
            return;
        end

        e      = cyc + 1;
        rx_exp = '0;
        for (int n = 0; n < beats; n++) begin
            lanev[n] = fixed ? pat[4*n +: 4] : 4'($urandom);
            if (dir == 1'b0) begin
                b.cyc  = e + t + int'(dummy) + n;
                b.mask = mask;
                b.val  = 4'((int'(data) >> (WORD - k * (n + 1))) & ((1 << k) - 1));
                wq_a.push_back(b);
            end else begin
                rx_exp = 8'((int'(rx_exp) << k) | int'(lanev[n] & mask));
            end
        end
        if (dir == 1'b1) begin
            r.cyc  = e + dur;
            r.data = rx_exp;
            rq_a.push_back(r);
        end

        cmd_valid_a = 1'b1;
        cmd_dir_a   = dir;
        cmd_mode_a  = mode;
        cmd_dummy_a = dummy;
        tx_data_a   = data;
        @(posedge sys_clk); #1;

        for (int c = 1; c <= dur; c++) begin
            if (dir == 1'b1) begin
                drv_oe_a = '1;
                drv_a    = (c > t + int'(dummy)) ? lanev[c - 1 - t - int'(dummy)] : 4'($urandom);
            end
            cmd_valid_a = 1'($urandom);
            cmd_dir_a   = 1'($urandom);
            cmd_mode_a  = 2'($urandom);
            cmd_dummy_a = 4'($urandom);
            tx_data_a   = 8'($urandom);
            if (c == dur) check("busy_last_cycle", 32'(busy_a), 32'd1);
            @(posedge sys_clk); #1;
        end
        cmd_valid_a = 1'b0;
        drv_oe_a    = '0;
        check("busy_done", 32'(busy_a), 32'd0);
        check("ready_done", 32'(cmd_ready_a), 32'd1);
        last_dir_a = dir;
    endtask

    // Write on DUT B, checked cycle by cycle.
    task automatic txn_b_write(input logic [1:0] mode, input logic [7:0] data);
        int         k, beats, t, dur, w, n;
        logic [1:0] m, expv;

        k     = model_lanes(int'(mode), LANES_B);
        beats = WORD / k;
        t     = (last_dir_b != 1'b0) ? 1 : 0;
        dur   = t + beats;
        m     = 2'((1 << k) - 1);

        w = 0;
        while (!cmd_ready_b && w < 40) begin
            @(posedge sys_clk); #1;
            w++;
        end
        if (!cmd_ready_b) begin
            check("b_ready_timeout", 32'(cmd_ready_b), 32'd1);
            return;
        end

        cmd_valid_b = 1'b1;
        cmd_dir_b   = 1'b0;
        cmd_mode_b  = mode;
        cmd_dummy_b = '0;
        tx_data_b   = data;
        @(posedge sys_clk); #1;
        cmd_valid_b = 1'b0;

        for (int c = 1; c <= dur; c++) begin
            if (c <= t) begin
                check("b_turn_oe", 32'(oe_b), 32'd0);
            end else begin
                n    = c - 1 - t;
                expv = 2'((int'(data) >> (WORD - k * (n + 1))) & ((1 << k) - 1));
                check("b_beat_oe", 32'(oe_b), 32'(m));
                check("b_beat_data", 32'(sio_b & m), 32'(expv));
            end
            @(posedge sys_clk); #1;
        end
        check("b_idle_oe", 32'(oe_b), 32'd0);
        check("b_busy_done", 32'(busy_b), 32'd0);
        last_dir_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rnd;
        sys_rst_n   = 1'b0;
        cmd_valid_a = 1'b0; cmd_dir_a = 1'b0; cmd_mode_a = '0; cmd_dummy_a = '0; tx_data_a = '0;
        cmd_valid_b = 1'b0; cmd_dir_b = 1'b0; cmd_mode_b = '0; cmd_dummy_b = '0; tx_data_b = '0;
        drv_a = '0; drv_oe_a = '0;

        // Reset held mid-clock, then released between edges
        repeat (2) @(posedge sys_clk);
        #3;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ready", 32'(cmd_ready_a), 32'd0);
        check("rst_oe", 32'(oe_a), 32'd0);
        check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        check("rst_rx_data", 32'(rx_data_a), 32'd0);
        sys_rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(cmd_ready_a), 32'd0);
        @(posedge sys_clk); #1;
        check("ready_after_edge", 32'(cmd_ready_a), 32'd1);
        mon_en = 1'b1;

        // 4-lane write after reset: turnaround, then A, 5
        txn_a(1'b0, 2'd2, 4'd0, 8'hA5, 1'b0, 32'h0);

        // 1-lane read, dummy 2, lane0 = 1,0,1,1,0,0,1,0
        txn_a(1'b1, 2'd0, 4'd2, 8'h00, 1'b1, 32'h0100_1101);
        check("rx_word_B2", 32'(rx_data_a), 32'hB2);

        // 2-lane write 0x3C then 4-lane read
        txn_a(1'b0, 2'd1, 4'd0, 8'h3C, 1'b0, 32'h0);
        txn_a(1'b1, 2'd2, 4'd0, 8'h00, 1'b0, 32'h0);

        // Largest dummy count
        txn_a(1'b1, 2'd1, 4'd15, 8'h00, 1'b0, 32'h0);
        txn_a(1'b0, 2'd3, 4'd15, 8'h5E, 1'b0, 32'h0);

        // Reset in the second beat of a write
        txn_a(1'b0, 2'd2, 4'd0, 8'h81, 1'b0, 32'h0);
        repeat (2) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        mon_en      = 1'b0;
        cmd_valid_a = 1'b1; cmd_dir_a = 1'b0; cmd_mode_a = 2'd2; cmd_dummy_a = '0; tx_data_a = 8'h96;
        @(posedge sys_clk); #1;
        cmd_valid_a = 1'b0;
        check("abort_beat0", 32'(sio_a), 32'h9);
        @(posedge sys_clk); #1;
        check("abort_beat1_oe", 32'(oe_a), 32'hF);
        #2 sys_rst_n = 1'b0;
        #1;
        check("abort_oe_async", 32'(oe_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ready", 32'(cmd_ready_a), 32'd0);
        @(posedge sys_clk); #1;
        check("abort_rx_valid", 32'(rx_valid_a), 32'd0);
        check("abort_rx_data", 32'(rx_data_a), 32'd0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        last_dir_a = 1'b1;
        last_dir_b = 1'b1;
        wq_a.delete();
        rq_a.delete();
        mon_en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rnd = 8'($urandom);
            txn_a(1'($urandom), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                  rnd, 1'b0, 32'h0);
        end

        // 2-lane instance: 4-lane modes clamp to 2 lanes
        txn_b_write(2'd2, 8'hC3);
        txn_b_write(2'd3, 8'($urandom));
        txn_b_write(2'd0, 8'($urandom));
        txn_b_write(2'd1, 8'($urandom));

        repeat (3) @(posedge sys_clk);
        #1;
        check("sb_beats_drained", wq_a.size(), 32'd0);
        check("sb_rx_drained", rq_a.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
